// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared deck constants, card type, dealer FSM states and index-to-card mapping.
package blackjack_pkg;
   localparam int DECK_SIZE = 52;
   localparam int RANKS     = 13;

   typedef struct packed {
      logic [3:0] rank;
      logic [1:0] suit;
   } card_t;

   typedef enum logic [2:0] {IDLE, REQ, CHECK, SCAN, DEAL} dealer_state_t;

   function automatic card_t idx_to_card(input int idx);
      card_t c;
      c.rank = 4'(idx % RANKS + 1);
      c.suit = 2'(idx / RANKS);
      return c;
   endfunction
endpackage

// File: rtl/deal_arbiter.sv
// deal_arbiter: sticky pending bits for player (0) and dealer (1) with round-robin grant.
module deal_arbiter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_shuffle,
   input  logic [1:0] i_req,
   input  logic [1:0] i_clr,
   input  logic       i_accept,
   output logic       o_grant_valid,
   output logic       o_grant_id
);
   logic [1:0] r_pend;
   logic       r_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
         r_last <= 1'b1;
      end else if (i_shuffle) begin
         r_pend <= '0;
      end else begin
         // a request in the same cycle as its clear re-arms the bit
         r_pend <= (r_pend & ~i_clr) | i_req;
         if (i_accept) r_last <= o_grant_id;
      end
   end

   assign o_grant_valid = |r_pend;
   assign o_grant_id    = (&r_pend) ? ~r_last : r_pend[1];
endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals unique cards from one deck using an external RNG, with retry and linear-scan fallback.
module card_dealer
   import blackjack_pkg::*;
#(
   parameter int DECK_SIZE   = 52,
   parameter int IDX_W       = 6,
   parameter int RETRY_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_shuffle,
   input  logic             i_player_req,
   input  logic             i_dealer_req,
   output logic             o_rng_request,
   input  logic [IDX_W-1:0] i_rng_value,
   output logic             o_deal_valid,
   output logic             o_deal_error,
   output logic             o_deal_to,
   output logic [3:0]       o_card_rank,
   output logic [1:0]       o_card_suit,
   output logic [IDX_W-1:0] o_cards_left,
   output logic             o_busy
);
   localparam int RW = $clog2(RETRY_LIMIT + 1);

   dealer_state_t          r_state, w_next;
   logic [DECK_SIZE-1:0]   r_used;
   logic [IDX_W-1:0]       r_val, r_idx, r_left;
   logic [RW-1:0]          r_retry;
   logic                   r_who, r_deal_valid, r_deal_error, r_deal_to;
   card_t                  r_card;
   logic                   w_gv, w_gid, w_accept, w_err;
   logic [1:0]             w_clr;
   logic [2**IDX_W-1:0]    w_used_ext;
   logic                   w_val_hit, w_scan_hit, w_last_try;
   logic [IDX_W-1:0]       w_idx_inc, w_val_mod;

   deal_arbiter u_arb (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_shuffle     (i_shuffle),
      .i_req         ({i_dealer_req, i_player_req}),
      .i_clr         (w_clr),
      .i_accept      (w_accept),
      .o_grant_valid (w_gv),
      .o_grant_id    (w_gid)
   );

   // out-of-deck indices read as used, so oversized RNG values are rejected rather than truncated
   assign w_used_ext = {{(2**IDX_W-DECK_SIZE){1'b1}}, r_used};
   assign w_val_hit  = !w_used_ext[r_val];
   assign w_scan_hit = !w_used_ext[r_idx];
   assign w_last_try = (r_retry == RW'(RETRY_LIMIT - 1));
   assign w_idx_inc  = (r_idx == IDX_W'(DECK_SIZE - 1)) ? '0 : r_idx + 1'b1;
   assign w_val_mod  = (r_val >= IDX_W'(DECK_SIZE)) ? r_val - IDX_W'(DECK_SIZE) : r_val;
   assign w_clr      = w_err ? (2'b01 << w_gid) : ((r_state == DEAL) ? (2'b01 << r_who) : 2'b00);

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_gv && r_left == '0) w_err = 1'b1;
            else if (w_gv) begin
               w_accept = 1'b1;
               w_next   = REQ;
            end
         end
         REQ:     w_next = CHECK;
         CHECK:   w_next = w_val_hit ? DEAL : (w_last_try ? SCAN : REQ);
         SCAN:    w_next = w_scan_hit ? DEAL : SCAN;
         DEAL:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_used       <= '0;
         r_left       <= IDX_W'(DECK_SIZE);
         r_val        <= '0;
         r_idx        <= '0;
         r_retry      <= '0;
         r_who        <= 1'b0;
         r_deal_valid <= 1'b0;
         r_deal_error <= 1'b0;
         r_deal_to    <= 1'b0;
         r_card       <= '0;
      end else if (i_shuffle) begin
         r_state      <= IDLE;
         r_used       <= '0;
         r_left       <= IDX_W'(DECK_SIZE);
         r_deal_valid <= 1'b0;
         r_deal_error <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_deal_valid <= (r_state == DEAL);
         r_deal_error <= w_err;
         if (w_accept) begin
            r_who   <= w_gid;
            r_retry <= '0;
         end
         if (w_err) r_deal_to <= w_gid;
         if (r_state == REQ) r_val <= i_rng_value;
         if (r_state == CHECK) begin
            if (w_val_hit) r_idx <= r_val;
            else if (w_last_try) r_idx <= w_val_mod;
            else r_retry <= r_retry + 1'b1;
         end
         if (r_state == SCAN && !w_scan_hit) r_idx <= w_idx_inc;
         if (r_state == DEAL) begin
            r_used[r_idx] <= 1'b1;
            r_left        <= r_left - 1'b1;
            r_deal_to     <= r_who;
            r_card        <= idx_to_card(int'(r_idx));
         end
      end
   end

   assign o_rng_request = (r_state == REQ);
   assign o_busy        = (r_state != IDLE);
   assign o_deal_valid  = r_deal_valid;
   assign o_deal_error  = r_deal_error;
   assign o_deal_to     = r_deal_to;
   assign o_card_rank   = r_card.rank;
   assign o_card_suit   = r_card.suit;
   assign o_cards_left  = r_left;
endmodule
